// File: rtl/cmd_reg_bank_pkg.sv
// Shared widths and elaboration-time helpers for the command-bus register bank.
package cmd_reg_bank_pkg;

  localparam int unsigned BUS_BYTE_W = 8;
  localparam int unsigned LEN_W      = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Extracts field idx of width w (<=32) from a flattened per-channel vector.
  function automatic logic [31:0] field32(input logic [1023:0] flat,
                                          input int unsigned   idx,
                                          input int unsigned   w);
    logic [1023:0] sh;
    logic [31:0]   mask;
    sh   = flat >> (idx * w);
    mask = (w >= 32) ? '1 : ((32'(1) << w) - 32'(1));
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/cmd_reg_channel.sv
// One register-bank address: frame assembly, partial-frame timeout, pulse revert
// and the show-ahead readback buffer.
module cmd_reg_channel
  import cmd_reg_bank_pkg::*;
#(
  parameter int unsigned           REG_BYTES = 2,
  parameter logic [8*REG_BYTES-1:0] RESET_VAL = '0,
  parameter logic                  IS_RO     = 1'b0,
  parameter logic                  IS_PULSE  = 1'b0,
  parameter int unsigned           PULSE_LEN = 4,
  parameter int unsigned           TIMEOUT   = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [BUS_BYTE_W-1:0]    data_i,
  input  logic                     valid_i,
  input  logic                     rdreq_i,
  input  logic [8*REG_BYTES-1:0]   status_i,
  output logic                     have_msg_o,
  output logic [LEN_W-1:0]         len_o,
  output logic [BUS_BYTE_W-1:0]    data_o,
  output logic [8*REG_BYTES-1:0]   reg_o,
  output logic                     wr_strobe_o
);

  localparam int unsigned REG_W = 8 * REG_BYTES;
  localparam int unsigned BCW   = (REG_BYTES > 1) ? clog2(REG_BYTES) : 1;
  localparam int unsigned PCW   = clog2(PULSE_LEN + 1);
  localparam int unsigned TCW   = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

  logic [BCW-1:0]        bcnt_q, bcnt_d, ptr_q, ptr_d;
  logic [REG_W-1:0]      shift_q, shift_d, reg_q, reg_d, buf_q, buf_d;
  logic [TCW-1:0]        to_q, to_d;
  logic [PCW-1:0]        pcnt_q, pcnt_d;
  logic                  strobe_q, strobe_d, have_q, have_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [BUS_BYTE_W-1:0] data_q, data_d;
  logic [REG_W+7:0]      asm_ext;
  logic [REG_W-1:0]      asm_val, view;
  logic                  done;

  assign asm_ext = {shift_q, data_i};
  assign asm_val = asm_ext[REG_W-1:0];
  assign done    = valid_i && (bcnt_q == BCW'(REG_BYTES - 1));

  always_comb begin
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    to_d     = to_q;
    reg_d    = reg_q;
    strobe_d = 1'b0;
    pcnt_d   = pcnt_q;
    buf_d    = buf_q;
    ptr_d    = ptr_q;
    have_d   = have_q;

    if (IS_PULSE && pcnt_q != '0) begin
      pcnt_d = pcnt_q - PCW'(1);
      if (pcnt_q == PCW'(1)) reg_d = RESET_VAL;
    end

    if (have_q && rdreq_i) begin
      if (ptr_q == BCW'(REG_BYTES - 1)) have_d = 1'b0;
      else                              ptr_d  = ptr_q + BCW'(1);
    end

    // A completing frame overrides both the pulse revert and a same-cycle rdreq.
    if (valid_i) begin
      to_d = '0;
      if (done) begin
        bcnt_d  = '0;
        shift_d = '0;
        if (!IS_RO) begin
          reg_d    = asm_val;
          strobe_d = 1'b1;
          if (IS_PULSE) pcnt_d = PCW'(PULSE_LEN);
        end
        buf_d  = IS_RO ? status_i : asm_val;
        ptr_d  = '0;
        have_d = 1'b1;
      end else begin
        bcnt_d  = bcnt_q + BCW'(1);
        shift_d = asm_val;
      end
    end else if (TIMEOUT != 0 && bcnt_q != '0) begin
      if (to_q == TCW'(TIMEOUT - 1)) begin
        bcnt_d  = '0;
        shift_d = '0;
        to_d    = '0;
      end else begin
        to_d = to_q + TCW'(1);
      end
    end

    view   = buf_d << {ptr_d, 3'b000};
    len_d  = have_d ? LEN_W'(REG_BYTES) : '0;
    data_d = have_d ? view[REG_W-1 -: 8] : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt_q   <= '0;
      shift_q  <= '0;
      to_q     <= '0;
      reg_q    <= RESET_VAL;
      strobe_q <= 1'b0;
      pcnt_q   <= '0;
      buf_q    <= '0;
      ptr_q    <= '0;
      have_q   <= 1'b0;
      len_q    <= '0;
      data_q   <= '0;
    end else begin
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      to_q     <= to_d;
      reg_q    <= reg_d;
      strobe_q <= strobe_d;
      pcnt_q   <= pcnt_d;
      buf_q    <= buf_d;
      ptr_q    <= ptr_d;
      have_q   <= have_d;
      len_q    <= len_d;
      data_q   <= data_d;
    end
  end

  assign have_msg_o  = have_q;
  assign len_o       = len_q;
  assign data_o      = data_q;
  assign reg_o       = reg_q;
  assign wr_strobe_o = strobe_q;

endmodule

// File: rtl/cmd_reg_bank.sv
// Parametrised register-bank slave on the command bus: one independent
// cmd_reg_channel per address.
module cmd_reg_bank
  import cmd_reg_bank_pkg::*;
#(
  parameter int unsigned                      N_REGS     = 8,
  parameter int unsigned                      REG_BYTES  = 2,
  parameter logic [8*REG_BYTES*N_REGS-1:0]    RESET_VAL  = '0,
  parameter logic [N_REGS-1:0]                RO_MASK    = '0,
  parameter logic [N_REGS-1:0]                PULSE_MASK = '0,
  parameter int unsigned                      PULSE_LEN  = 4,
  parameter int unsigned                      TIMEOUT    = 65535
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        master_data,
  input  logic [N_REGS-1:0]                 valid_bus,
  input  logic [N_REGS-1:0]                 rdreq_bus,
  output logic [N_REGS-1:0]                 have_msg_bus,
  output logic [8*N_REGS-1:0]               len_bus,
  output logic [8*N_REGS-1:0]               slave_data_bus,
  output logic [8*REG_BYTES*N_REGS-1:0]     regs_out,
  input  logic [8*REG_BYTES*N_REGS-1:0]     status_in,
  output logic [N_REGS-1:0]                 wr_strobe
);

  localparam int unsigned REG_W = 8 * REG_BYTES;

  for (genvar i = 0; i < N_REGS; i++) begin : g_ch
    cmd_reg_channel #(
      .REG_BYTES (REG_BYTES),
      .RESET_VAL (REG_W'(field32(1024'(RESET_VAL), i, REG_W))),
      .IS_RO     (RO_MASK[i]),
      .IS_PULSE  (PULSE_MASK[i]),
      .PULSE_LEN (PULSE_LEN),
      .TIMEOUT   (TIMEOUT)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .data_i      (master_data),
      .valid_i     (valid_bus[i]),
      .rdreq_i     (rdreq_bus[i]),
      .status_i    (status_in[REG_W*i +: REG_W]),
      .have_msg_o  (have_msg_bus[i]),
      .len_o       (len_bus[LEN_W*i +: LEN_W]),
      .data_o      (slave_data_bus[BUS_BYTE_W*i +: BUS_BYTE_W]),
      .reg_o       (regs_out[REG_W*i +: REG_W]),
      .wr_strobe_o (wr_strobe[i])
    );
  end

endmodule

// File: tb/tb_cmd_reg_bank.sv
// Directed bench for cmd_reg_bank: readback bytes are queued when a write is
// driven and popped when the channel presents its message.
module tb_cmd_reg_bank;

  localparam int unsigned N  = 8;
  localparam int unsigned RB = 2;
  localparam logic [127:0] RV = 128'hA5A5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         master_data = '0;
  logic [N-1:0]       valid_bus = '0;
  logic [N-1:0]       rdreq_bus = '0;
  logic [N-1:0]       have_msg_bus;
  logic [8*N-1:0]     len_bus;
  logic [8*N-1:0]     slave_data_bus;
  logic [8*RB*N-1:0]  regs_out;
  logic [8*RB*N-1:0]  status_in = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_BEEF;
  logic [N-1:0]       wr_strobe;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  exp_q[$];

  cmd_reg_bank #(
    .N_REGS     (N),
    .REG_BYTES  (RB),
    .RESET_VAL  (RV),
    .RO_MASK    (8'h01),
    .PULSE_MASK (8'h04),
    .PULSE_LEN  (4),
    .TIMEOUT    (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .master_data    (master_data),
    .valid_bus      (valid_bus),
    .rdreq_bus      (rdreq_bus),
    .have_msg_bus   (have_msg_bus),
    .len_bus        (len_bus),
    .slave_data_bus (slave_data_bus),
    .regs_out       (regs_out),
    .status_in      (status_in),
    .wr_strobe      (wr_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reg_of(input int unsigned ch);
    return regs_out[16*ch +: 16];
  endfunction

  function automatic logic [7:0] data_of(input int unsigned ch);
    return slave_data_bus[8*ch +: 8];
  endfunction

  task automatic send_byte(input int unsigned ch, input logic [7:0] b);
    master_data = b;
    valid_bus   = N'(1) << ch;
    step();
    valid_bus   = '0;
  endtask

  // Returns in the completion cycle (T+1).
  task automatic write2(input int unsigned ch, input logic [15:0] v);
    master_data = v[15:8];
    valid_bus   = N'(1) << ch;
    step();
    master_data = v[7:0];
    step();
    valid_bus   = '0;
  endtask

  task automatic read_msg(input int unsigned ch, input int unsigned n);
    logic [7:0] last;
    last = '0;
    for (int unsigned k = 0; k < n; k++) begin
      chk($sformatf("have_msg ch%0d b%0d", ch, k), 128'(have_msg_bus[ch]), 128'(1));
      chk($sformatf("len ch%0d b%0d", ch, k), 128'(len_bus[8*ch +: 8]), 128'(RB));
      last = exp_q.pop_front();
      chk($sformatf("data ch%0d b%0d", ch, k), 128'(data_of(ch)), 128'(last));
      rdreq_bus = N'(1) << ch;
      step();
      rdreq_bus = '0;
      chk($sformatf("strobe idle ch%0d b%0d", ch, k), 128'(wr_strobe), 128'(0));
    end
    chk($sformatf("have_msg clear ch%0d", ch), 128'(have_msg_bus[ch]), 128'(0));
    chk($sformatf("len clear ch%0d", ch), 128'(len_bus[8*ch +: 8]), 128'(0));
    chk($sformatf("data hold ch%0d", ch), 128'(data_of(ch)), 128'(last));
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst regs", 128'(regs_out), RV);
    chk("rst have_msg", 128'(have_msg_bus), 128'(0));
    chk("rst len", 128'(len_bus), 128'(0));
    chk("rst data", 128'(slave_data_bus), 128'(0));
    chk("rst strobe", 128'(wr_strobe), 128'(0));
    rst = 1'b0;
    step();

    // 1: plain write and readback on ch3
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    write2(3, 16'h1234);
    chk("s1 reg3", 128'(reg_of(3)), 128'h1234);
    chk("s1 strobe", 128'(wr_strobe), 128'h08);
    chk("s1 have_msg", 128'(have_msg_bus), 128'h08);
    read_msg(3, 2);

    // 2: read-only ch0 returns status, keeps reset value
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    write2(0, 16'h0000);
    chk("s2 reg0", 128'(reg_of(0)), 128'hA5A5);
    chk("s2 strobe", 128'(wr_strobe), 128'(0));
    read_msg(0, 2);

    // 3: pulse ch2, held 4 cycles, rewrite reloads
    write2(2, 16'h00FF);
    chk("s3 c0", 128'(reg_of(2)), 128'h00FF);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
    master_data = 8'h0F; valid_bus = 8'h04;
    step();
    chk("s3 c1", 128'(reg_of(2)), 128'h00FF);
    step();
    valid_bus = '0;
    chk("s3 c2 rewrite", 128'(reg_of(2)), 128'h0F0F);
    chk("s3 c2 strobe", 128'(wr_strobe), 128'h04);
    for (int unsigned c = 3; c < 6; c++) begin
      step();
      chk($sformatf("s3 hold c%0d", c), 128'(reg_of(2)), 128'h0F0F);
    end
    step();
    chk("s3 revert", 128'(reg_of(2)), 128'h0000);
    chk("s3 no strobe", 128'(wr_strobe), 128'(0));
    read_msg(2, 2);

    // 4: timeout on ch1; 9 idle cycles keep the frame, 10 drop it
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    send_byte(1, 8'h77);
    repeat (9) step();
    send_byte(1, 8'h88);
    chk("s4 keep", 128'(reg_of(1)), 128'h7788);
    read_msg(1, 2);
    send_byte(1, 8'hAA);
    repeat (10) step();
    chk("s4 drop no msg", 128'(have_msg_bus), 128'(0));
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    write2(1, 16'h5566);
    chk("s4 reg1", 128'(reg_of(1)), 128'h5566);
    chk("s4 have_msg", 128'(have_msg_bus), 128'h02);
    read_msg(1, 2);

    // 5: overwrite pending message on ch5; completion beats rdreq
    write2(5, 16'h1133);
    chk("s5 b0", 128'(data_of(5)), 128'h11);
    rdreq_bus = 8'h20; step(); rdreq_bus = '0;
    chk("s5 b1", 128'(data_of(5)), 128'h33);
    write2(5, 16'h2244);
    chk("s5 ptr reset", 128'(data_of(5)), 128'h22);
    rdreq_bus = 8'h20; step(); rdreq_bus = '0;
    chk("s5 adv", 128'(data_of(5)), 128'h44);
    master_data = 8'h66; valid_bus = 8'h20;
    step();
    master_data = 8'h77; rdreq_bus = 8'h20;
    step();
    valid_bus = '0; rdreq_bus = '0;
    chk("s5 coinc have", 128'(have_msg_bus[5]), 128'(1));
    chk("s5 coinc data", 128'(data_of(5)), 128'h66);
    exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    read_msg(5, 2);

    // 6: reset mid-frame on ch4 with a message pending on ch6
    write2(6, 16'h9876);
    send_byte(4, 8'hC3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6 regs", 128'(regs_out), RV);
    chk("s6 have_msg", 128'(have_msg_bus), 128'(0));
    chk("s6 len", 128'(len_bus), 128'(0));
    chk("s6 data", 128'(slave_data_bus), 128'(0));
    chk("s6 strobe", 128'(wr_strobe), 128'(0));
    exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
    write2(4, 16'hABCD);
    chk("s6 reg4", 128'(reg_of(4)), 128'hABCD);
    chk("s6 wstrobe", 128'(wr_strobe), 128'h10);
    read_msg(4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
